// File: rtl/idu_pkg.sv
// idu_pkg: shared definitions for the integer decode stage.
//   - 5-bit major opcode values (instr[6:2]), including the RV64 word-op groups
//   - instruction-format and memory-size enums
//   - decoded_t: the bundle carried from decode through the skid buffer.
//     Its pc/imm members are sized for the widest XLEN (64). The narrower
//     build uses only the low bits.
//   - load_bad/store_bad: illegal funct3 checks for loads and stores
package idu_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_32     = 5'b01110;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef enum logic [1:0] {
    MM_BYTE  = 2'b00,
    MM_HALF  = 2'b01,
    MM_WORD  = 2'b10,
    MM_DWORD = 2'b11
  } mm_size_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                rd_we;
    logic [2:0]          alu_funct3;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                op1_pc;
    logic                op2_imm;
    logic                jump;
    logic                branch;
    logic                mm_we;
    logic                mm_re;
    mm_size_e            mm_size;
    logic                mm_unsigned;
    logic                word_op;
    logic                illegal;
    logic                muldiv;
  } decoded_t;

  // Doubleword and unsigned-word loads exist only on RV64; 111 never exists.
  function automatic logic load_bad(input logic [2:0] f3, input logic is64);
    return (f3 == 3'b111) || (!is64 && ((f3 == 3'b011) || (f3 == 3'b110)));
  endfunction

  function automatic logic store_bad(input logic [2:0] f3, input logic is64);
    return f3[2] || (!is64 && (f3 == 3'b011));
  endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// idu_decode_comb: purely combinational instruction -> decoded_t.
// Ports:
//   instr  in  32         raw instruction
//   dec    out decoded_t  decoded bundle (pc member left at 0, filled by the caller)
// Parameter XLEN (32/64) selects RV32 or RV64 legality, shamt width and
// funct7 masking. Macro IDU_PIPE_M_EXT_EN makes funct7=0000001 on OP/OP-32 a
// legal mul/div op; without it that encoding is illegal.
module idu_decode_comb
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  localparam logic IS64 = (XLEN == 64);

  logic [4:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic               is_word;
  logic               is_shift;
  logic               ill;
  fmt_e               fmt;
  logic signed [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    opc      = instr[6:2];
    f3       = instr[14:12];
    f7       = instr[31:25];
    is_word  = (opc == OP_IMM_32) || (opc == OP_32);
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    imm_i = {{52{instr[31]}}, instr[31:20]};
    imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {{32{instr[31]}}, instr[31:12], 12'h000};
    imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    dec        = '0;
    dec.funct3 = f3;
    fmt        = FMT_NONE;
    ill        = 1'b0;

    case (opc)
      OP_LUI: begin
        fmt = FMT_U; dec.rd_we = 1'b1; dec.op2_imm = 1'b1;
      end
      OP_AUIPC: begin
        fmt = FMT_U; dec.rd_we = 1'b1; dec.op1_pc = 1'b1; dec.op2_imm = 1'b1;
      end
      OP_JAL: begin
        fmt = FMT_J; dec.rd_we = 1'b1; dec.jump = 1'b1;
        dec.op1_pc = 1'b1; dec.op2_imm = 1'b1;
      end
      OP_JALR: begin
        fmt = FMT_I; dec.rd_we = 1'b1; dec.jump = 1'b1; dec.op2_imm = 1'b1;
      end
      OP_BRANCH: begin
        fmt = FMT_B; dec.branch = 1'b1;
      end
      OP_LOAD: begin
        fmt = FMT_I; dec.rd_we = 1'b1; dec.mm_re = 1'b1; dec.op2_imm = 1'b1;
        dec.mm_size     = mm_size_e'(f3[1:0]);
        dec.mm_unsigned = f3[2];
        ill = load_bad(f3, IS64);
      end
      OP_STORE: begin
        fmt = FMT_S; dec.mm_we = 1'b1; dec.op2_imm = 1'b1;
        dec.mm_size = mm_size_e'(f3[1:0]);
        ill = store_bad(f3, IS64);
      end
      OP_IMM, OP_IMM_32: begin
        fmt = FMT_I; dec.rd_we = 1'b1; dec.op2_imm = 1'b1;
        dec.alu_funct3 = f3; dec.word_op = is_word;
        ill = is_word && !IS64;
      end
      OP_OP, OP_32: begin
        fmt = FMT_R; dec.rd_we = 1'b1;
        dec.alu_funct3 = f3; dec.funct7 = f7; dec.word_op = is_word;
        ill = is_word && !IS64;
        if (f7 == 7'b0000001) begin
`ifdef IDU_PIPE_M_EXT_EN
          dec.muldiv = 1'b1;
`else
          ill = 1'b1;
`endif
        end
      end
      OP_FENCE, OP_SYSTEM: ;
      default: ill = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) ill = 1'b1;

    // Only the fields a format actually uses are driven, so hazard logic
    // never sees phantom register dependencies.
    case (fmt)
      FMT_R: begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; end
      FMT_I: begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i; end
      FMT_S: begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = imm_s; end
      FMT_B: begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = imm_b; end
      FMT_U: begin dec.rd = instr[11:7]; dec.imm = imm_u; end
      FMT_J: begin dec.rd = instr[11:7]; dec.imm = imm_j; end
      default: ;
    endcase

    // Immediate shifts: shamt is 6 bits only for full-width RV64 shifts;
    // on RV64 funct7[0] is shamt[5], so it is cleared from funct7.
    if (((opc == OP_IMM) || (opc == OP_IMM_32)) && is_shift) begin
      dec.funct7 = {f7[6:1], IS64 ? 1'b0 : f7[0]};
      dec.imm    = (IS64 && !is_word) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
    end

    if (ill) begin
      dec.rd_we  = 1'b0;
      dec.mm_we  = 1'b0;
      dec.mm_re  = 1'b0;
      dec.jump   = 1'b0;
      dec.branch = 1'b0;
      dec.rd     = '0;
      dec.rs1    = '0;
      dec.rs2    = '0;
    end
    dec.illegal = ill;
  end

endmodule

// File: rtl/idu_pipe.sv
// idu_pipe: registered integer decode stage with an output skid buffer.
// Accepts {instr_in, pc_in} on in_valid/in_ready, decodes combinationally and
// stores the bundle in a SKID_DEPTH-entry FIFO presented oldest-first on
// out_valid/out_ready. Latency is one cycle. in_ready is a flop, so there is no
// combinational path from out_ready to in_ready. flush discards every held
// entry and drops the input offered on the same edge.
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready, instr_in,
// pc_in, out_valid/out_ready, and the decoded bundle fields (pc_out, imm, rd,
// rs1, rs2, rd_we, alu_funct3, funct3, funct7, op1_pc, op2_imm, jump, branch,
// mm_we, mm_re, mm_size, mm_unsigned, word_op, illegal).
// The muldiv output exists only when IDU_PIPE_M_EXT_EN is defined.
// Bundle outputs read as 0 whenever out_valid is low, including after reset.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            rd_we,
  output logic [2:0]      alu_funct3,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            op1_pc,
  output logic            op2_imm,
  output logic            jump,
  output logic            branch,
  output logic            mm_we,
  output logic            mm_re,
  output logic [1:0]      mm_size,
  output logic            mm_unsigned,
  output logic            word_op,
`ifdef IDU_PIPE_M_EXT_EN
  output logic            muldiv,
`endif
  output logic            illegal
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  decoded_t      dec_raw;
  decoded_t      dec_p0;
  decoded_t      ent_p1 [SKID_DEPTH];
  decoded_t      head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic          vld_p1;
  logic          unused_hi;

  // ---- p0: combinational decode
  idu_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr (instr_in),
    .dec   (dec_raw)
  );

  always_comb begin
    dec_p0    = dec_raw;
    dec_p0.pc = XLEN_MAX'(pc_in);
  end

  // ---- p1: skid buffer (flush outranks both handshakes)
  assign push      = in_valid && in_ready && !flush;
  assign pop       = vld_p1 && out_ready && !flush;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign vld_p1    = (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != CW'(SKID_DEPTH));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_p1[wr_ptr] <= dec_p0;
  end

  always_comb begin
    head = vld_p1 ? ent_p1[rd_ptr] : '0;
  end

  assign out_valid   = vld_p1;
  assign pc_out      = head.pc[XLEN-1:0];
  assign imm         = head.imm[XLEN-1:0];
  assign rd          = head.rd;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign rd_we       = head.rd_we;
  assign alu_funct3  = head.alu_funct3;
  assign funct3      = head.funct3;
  assign funct7      = head.funct7;
  assign op1_pc      = head.op1_pc;
  assign op2_imm     = head.op2_imm;
  assign jump        = head.jump;
  assign branch      = head.branch;
  assign mm_we       = head.mm_we;
  assign mm_re       = head.mm_re;
  assign mm_size     = head.mm_size;
  assign mm_unsigned = head.mm_unsigned;
  assign word_op     = head.word_op;
  assign illegal     = head.illegal;

`ifdef IDU_PIPE_M_EXT_EN
  assign muldiv    = head.muldiv;
  assign unused_hi = ^{head.pc, head.imm};
`else
  assign unused_hi = ^{head.pc, head.imm, head.muldiv};
`endif

endmodule

// File: tb/tb_idu_pipe.sv
module tb_idu_pipe;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_we;
    logic [2:0]  alu_funct3, funct3;
    logic [6:0]  funct7;
    logic        op1_pc, op2_imm, jump, branch, mm_we, mm_re;
    logic [1:0]  mm_size;
    logic        mm_unsigned, word_op, illegal, muldiv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr_in;
  logic [63:0] pc_in;

  // dut_a: XLEN=32, dut_b: XLEN=64
  logic        in_ready_a, out_valid_a, rd_we_a, op1_pc_a, op2_imm_a, jump_a, branch_a;
  logic        mm_we_a, mm_re_a, mm_unsigned_a, word_op_a, illegal_a, muldiv_a;
  logic [31:0] pc_out_a, imm_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  alu_funct3_a, funct3_a;
  logic [6:0]  funct7_a;
  logic [1:0]  mm_size_a;
  logic        in_ready_b, out_valid_b, rd_we_b, op1_pc_b, op2_imm_b, jump_b, branch_b;
  logic        mm_we_b, mm_re_b, mm_unsigned_b, word_op_b, illegal_b, muldiv_b;
  logic [63:0] pc_out_b, imm_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  alu_funct3_b, funct3_b;
  logic [6:0]  funct7_b;
  logic [1:0]  mm_size_b;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .SKID_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr_in(instr_in), .pc_in(pc_in[31:0]), .out_valid(out_valid_a), .out_ready(out_ready),
    .pc_out(pc_out_a), .imm(imm_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .rd_we(rd_we_a),
    .alu_funct3(alu_funct3_a), .funct3(funct3_a), .funct7(funct7_a), .op1_pc(op1_pc_a),
    .op2_imm(op2_imm_a), .jump(jump_a), .branch(branch_a), .mm_we(mm_we_a), .mm_re(mm_re_a),
    .mm_size(mm_size_a), .mm_unsigned(mm_unsigned_a), .word_op(word_op_a),
`ifdef IDU_PIPE_M_EXT_EN
    .muldiv(muldiv_a),
`endif
    .illegal(illegal_a)
  );

  idu_pipe #(.XLEN(64), .SKID_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr_in(instr_in), .pc_in(pc_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .pc_out(pc_out_b), .imm(imm_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .rd_we(rd_we_b),
    .alu_funct3(alu_funct3_b), .funct3(funct3_b), .funct7(funct7_b), .op1_pc(op1_pc_b),
    .op2_imm(op2_imm_b), .jump(jump_b), .branch(branch_b), .mm_we(mm_we_b), .mm_re(mm_re_b),
    .mm_size(mm_size_b), .mm_unsigned(mm_unsigned_b), .word_op(word_op_b),
`ifdef IDU_PIPE_M_EXT_EN
    .muldiv(muldiv_b),
`endif
    .illegal(illegal_b)
  );

`ifndef IDU_PIPE_M_EXT_EN
  assign muldiv_a = 1'b0;
  assign muldiv_b = 1'b0;
`endif

  // Reference decoder: builds the bundle straight from the ISA field rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    exp_t        e;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] im_i, im_s, im_b, im_u, im_j;
    bit          ill, w;
    int          sh_bits;
    e    = '0;
    op   = ins[6:2];
    f3   = ins[14:12];
    f7   = ins[31:25];
    w    = (op == 5'b00110) || (op == 5'b01110);
    ill  = 0;
    im_i = 64'($signed(ins[31:20]));
    im_s = 64'($signed({ins[31:25], ins[11:7]}));
    im_b = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    im_u = 64'($signed({ins[31:12], 12'h000}));
    im_j = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.pc = pc;
    e.funct3 = f3;
    case (op)
      5'b01101: begin e.rd = ins[11:7]; e.rd_we = 1; e.op2_imm = 1; e.imm = im_u; end
      5'b00101: begin e.rd = ins[11:7]; e.rd_we = 1; e.op1_pc = 1; e.op2_imm = 1; e.imm = im_u; end
      5'b11011: begin
        e.rd = ins[11:7]; e.rd_we = 1; e.jump = 1; e.op1_pc = 1; e.op2_imm = 1; e.imm = im_j;
      end
      5'b11001: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rd_we = 1; e.jump = 1; e.op2_imm = 1; e.imm = im_i;
      end
      5'b11000: begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.branch = 1; e.imm = im_b; end
      5'b00000: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rd_we = 1; e.mm_re = 1; e.op2_imm = 1;
        e.imm = im_i; e.mm_size = f3[1:0]; e.mm_unsigned = f3[2];
        ill = (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6));
      end
      5'b01000: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.mm_we = 1; e.op2_imm = 1; e.imm = im_s;
        e.mm_size = f3[1:0];
        ill = (f3 >= 3'd4) || (xlen == 32 && f3 == 3'd3);
      end
      5'b00100, 5'b00110: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rd_we = 1; e.op2_imm = 1;
        e.alu_funct3 = f3; e.word_op = w;
        ill = w && (xlen == 32);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          sh_bits = (xlen == 32 || w) ? 5 : 6;
          e.imm = 64'(ins[25:20]) & ((64'd1 << sh_bits) - 64'd1);
          e.funct7 = (xlen == 64) ? (f7 & 7'h7E) : f7;
        end else begin
          e.imm = im_i;
        end
      end
      5'b01100, 5'b01110: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd_we = 1;
        e.alu_funct3 = f3; e.funct7 = f7; e.word_op = w;
        ill = w && (xlen == 32);
        if (f7 == 7'd1) begin
`ifdef IDU_PIPE_M_EXT_EN
          e.muldiv = 1;
`else
          ill = 1;
`endif
        end
      end
      5'b00011, 5'b11100: ;
      default: ill = 1;
    endcase
    if (ins[1:0] != 2'b11) ill = 1;
    if (ill) begin
      e.rd_we = 0; e.mm_we = 0; e.mm_re = 0; e.jump = 0; e.branch = 0;
      e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    end
    e.illegal = ill;
    if (xlen == 32) begin
      e.imm[63:32] = '0;
      e.pc[63:32]  = '0;
    end
    return e;
  endfunction

  function automatic exp_t act_a();
    exp_t a;
    a = '0;
    a.pc = 64'(pc_out_a); a.imm = 64'(imm_a);
    a.rd = rd_a; a.rs1 = rs1_a; a.rs2 = rs2_a; a.rd_we = rd_we_a;
    a.alu_funct3 = alu_funct3_a; a.funct3 = funct3_a; a.funct7 = funct7_a;
    a.op1_pc = op1_pc_a; a.op2_imm = op2_imm_a; a.jump = jump_a; a.branch = branch_a;
    a.mm_we = mm_we_a; a.mm_re = mm_re_a; a.mm_size = mm_size_a; a.mm_unsigned = mm_unsigned_a;
    a.word_op = word_op_a; a.illegal = illegal_a; a.muldiv = muldiv_a;
    return a;
  endfunction

  function automatic exp_t act_b();
    exp_t a;
    a = '0;
    a.pc = pc_out_b; a.imm = imm_b;
    a.rd = rd_b; a.rs1 = rs1_b; a.rs2 = rs2_b; a.rd_we = rd_we_b;
    a.alu_funct3 = alu_funct3_b; a.funct3 = funct3_b; a.funct7 = funct7_b;
    a.op1_pc = op1_pc_b; a.op2_imm = op2_imm_b; a.jump = jump_b; a.branch = branch_b;
    a.mm_we = mm_we_b; a.mm_re = mm_re_b; a.mm_size = mm_size_b; a.mm_unsigned = mm_unsigned_b;
    a.word_op = word_op_b; a.illegal = illegal_b; a.muldiv = muldiv_b;
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input exp_t act, input exp_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard bookkeeping on the active edge: mirrors transfers into queues.
  always @(posedge clk) begin
    if (rst || flush) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (out_valid_a && out_ready && q_a.size() != 0) void'(q_a.pop_front());
      if (out_valid_b && out_ready && q_b.size() != 0) void'(q_b.pop_front());
      if (in_valid && in_ready_a) q_a.push_back(model(instr_in, pc_in, 32));
      if (in_valid && in_ready_b) q_b.push_back(model(instr_in, pc_in, 64));
    end
  end

  // Monitor: on the falling edge compare presented bundles and flow control.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid_a", 64'(out_valid_a), 64'(q_a.size() != 0));
      chk("in_ready_a", 64'(in_ready_a), 64'(q_a.size() < 2));
      if (out_valid_a && q_a.size() != 0) chkb("bundle_a", act_a(), q_a[0]);
      chk("out_valid_b", 64'(out_valid_b), 64'(q_b.size() != 0));
      chk("in_ready_b", 64'(in_ready_b), 64'(q_b.size() < 2));
      if (out_valid_b && q_b.size() != 0) chkb("bundle_b", act_b(), q_b[0]);
    end
  end

  task automatic issue1(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1; instr_in = ins; pc_in = pc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  op;
    r = $urandom;
    case ($urandom_range(0, 14))
      0: op = 5'b00000;  1: op = 5'b00011;  2: op = 5'b00100;  3: op = 5'b00101;
      4: op = 5'b00110;  5: op = 5'b01000;  6: op = 5'b01100;  7: op = 5'b01101;
      8: op = 5'b01110;  9: op = 5'b11000; 10: op = 5'b11001; 11: op = 5'b11011;
      12: op = 5'b11100;
      default: op = r[6:2];
    endcase
    r[6:2] = op;
    if ($urandom_range(0, 9) != 0) r[1:0] = 2'b11;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'b0000001;
      1: r[31:25] = 7'b0000000;
      2: r[31:25] = 7'b0100000;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] bp [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

  initial begin
    int k;
    int cyc;
    logic acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_in = '0; pc_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    chkb("rst_bundle_a", act_a(), '0);
    chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    chkb("rst_bundle_b", act_b(), '0);

    // addi x1,x0,5
    issue1(32'h00500093, 64'h100);
    chk("addi_valid", 64'(out_valid_a), 64'd1);
    chk("addi_rd", 64'(rd_a), 64'd1);
    chk("addi_rs1", 64'(rs1_a), 64'd0);
    chk("addi_rs2", 64'(rs2_a), 64'd0);
    chk("addi_imm", 64'(imm_a), 64'd5);
    chk("addi_op2imm", 64'(op2_imm_a), 64'd1);
    chk("addi_rdwe", 64'(rd_we_a), 64'd1);
    chk("addi_pc", 64'(pc_out_a), 64'h100);

    // lui x2,0x12345
    issue1(32'h12345137, 64'h104);
    chk("lui_imm", 64'(imm_a), 64'h12345000);
    chk("lui_rd", 64'(rd_a), 64'd2);
    chk("lui_alu", 64'(alu_funct3_a), 64'd0);
    chk("lui_op2imm", 64'(op2_imm_a), 64'd1);
    issue1(32'h80000137, 64'h108);
    chk("lui_neg_imm64", imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("lui_neg_imm32", 64'(imm_a), 64'h8000_0000);

    // all-zero word is illegal
    issue1(32'h00000000, 64'h10C);
    chk("zero_illegal", 64'(illegal_a), 64'd1);
    chk("zero_enables", 64'({rd_we_a, mm_we_a, mm_re_a, jump_a, branch_a}), 64'd0);

    // lbu x3,4(x1)
    issue1(32'h0040C183, 64'h110);
    chk("lbu_re", 64'(mm_re_a), 64'd1);
    chk("lbu_size", 64'(mm_size_a), 64'd0);
    chk("lbu_uns", 64'(mm_unsigned_a), 64'd1);
    chk("lbu_imm", 64'(imm_a), 64'd4);
    chk("lbu_rd", 64'(rd_a), 64'd3);
    chk("lbu_rs1", 64'(rs1_a), 64'd1);

    // addiw x5,x5,-1
    issue1(32'hFFF2829B, 64'h114);
    chk("addiw_word64", 64'(word_op_b), 64'd1);
    chk("addiw_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw_legal64", 64'(illegal_b), 64'd0);
    chk("addiw_illegal32", 64'(illegal_a), 64'd1);
    @(posedge clk); #1;

    // back-pressure: 4 instructions, consumer stalled
    out_ready = 1'b0; k = 0; cyc = 0;
    while (k < 2 && cyc < 20) begin
      in_valid = 1'b1; instr_in = bp[k]; pc_in = 64'h200 + 64'(k * 4);
      acc = in_ready_a;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    chk("bp_two_accepted", 64'(k), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready_a), 64'd0);
    instr_in = bp[2]; pc_in = 64'h208;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      in_valid = 1'b1; instr_in = bp[k]; pc_in = 64'h200 + 64'(k * 4);
      acc = in_ready_a;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    chk("bp_all_accepted", 64'(k), 64'd4);
    in_valid = 1'b0;
    cyc = 0;
    while (q_a.size() != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("bp_drained", 64'(q_a.size()), 64'd0);

    // flush with two entries held and an input offered
    out_ready = 1'b0;
    issue1(32'h00A00513, 64'h300);
    out_ready = 1'b0;
    issue1(32'h00B00593, 64'h304);
    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 32'h00C00613; pc_in = 64'h308; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid_a", 64'(out_valid_a), 64'd0);
    chk("flush2_out_valid_b", 64'(out_valid_b), 64'd0);
    chk("flush2_in_ready", 64'(in_ready_a), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // flush with one entry held while the offer could have been accepted
    #1 out_ready = 1'b0;
    issue1(32'h00D00693, 64'h400);
    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 32'h00E00713; pc_in = 64'h404; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", 64'(out_valid_a), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      instr_in  = rand_instr();
      pc_in     = {$urandom, $urandom} & ~64'd3;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("final_drain_a", 64'(q_a.size()), 64'd0);
    chk("final_drain_b", 64'(q_b.size()), 64'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Registered, parametrised integer decode stage.
- Sits between fetch and issue/execute. Accepts a 32-bit instruction plus its PC over a valid/ready handshake and presents one decoded bundle per cycle downstream.
- Generalises the combinational decoder in four ways:
  - XLEN 32/64, including RV64 word ops (OP-IMM-32/OP-32).
  - Explicit load/store size and sign controls.
  - Illegal-instruction flagging.
  - A skid buffer so back-pressure never creates a combinational ready path.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- SKID_DEPTH, 2, number of output-side entries (1 = plain pipeline register, 2 = full-throughput skid buffer).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries (branch/jump redirect)
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept this cycle
- instr_in  in  32  raw instruction
- pc_in  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts this cycle
- pc_out  out  XLEN  PC of decoded instruction
- imm  out  XLEN  sign/zero-extended immediate
- rd, rs1, rs2  out  5 each  register indices; 0 when unused
- rd_we  out  1  register write enable
- alu_funct3  out  3  ALU operation
- funct3  out  3  raw funct3
- funct7  out  7  funct7; 0 when unused
- op1_pc, op2_imm  out  1 each  ALU operand selects
- jump, branch  out  1 each  JBU control
- mm_we, mm_re  out  1 each  memory write/read enables
- mm_size  out  2  00 byte, 01 half, 10 word, 11 dword
- mm_unsigned  out  1  zero-extend load data
- word_op  out  1  RV64 32-bit op; result is sign-extended from bit 31
- illegal  out  1  unrecognised encoding

Behaviour:
- Reset: clock and reset are as already decided (one clock; synchronous active-high reset). While rst is high on a clk edge:
  - Skid buffer emptied, out_valid=0.
  - All bundle outputs forced to 0.
  - in_ready=1 in the following cycle.
- Latency: 1 cycle. An instruction accepted on edge N appears with out_valid=1 after edge N.
- Handshakes: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- in_ready is a registered value: high unless the buffer holds SKID_DEPTH entries.
- SKID_DEPTH=2 with out_ready held high gives one instruction per cycle.
- Output entries are presented oldest-first. A presented bundle stays stable until it is taken.
- Simultaneous accept and take when full: not possible, because in_ready=0 when full. Taking an entry raises in_ready on the next cycle.
- flush: on the edge it is sampled high, all entries are discarded and any input offered that cycle is dropped. Next cycle out_valid=0. flush has priority over in_valid and out_ready.
- Decode rules, applied before registering:
  - Opcode bits [6:2] use the same formats as the existing decode.
  - Unused rd/rs1/rs2/funct7 are driven to 0 to avoid false hazards.
  - LOAD: mm_size=funct3[1:0], mm_unsigned=funct3[2].
  - STORE: mm_size=funct3[1:0], mm_unsigned=0.
  - Shift immediates: shamt is 5 bits when XLEN=32 or for word_op; 6 bits otherwise. funct7 bit 0 is masked when XLEN=64.
  - U-type imm is sign-extended from bit 31 to XLEN.
- illegal=1 for any of:
  - instr_in[1:0]!=2'b11
  - unknown opcode
  - LOAD funct3 in {011 when XLEN=32, 111, 110 when XLEN=32}
  - STORE funct3[2]=1 or (XLEN=32 and funct3=011)
  - OP-IMM-32/OP-32 when XLEN=32
- When illegal=1: rd_we, mm_we, mm_re, jump and branch are forced to 0. rd, rs1 and rs2 are forced to 0. The bundle still flows, so a trap unit can act on it.
- FENCE/SYSTEM: decoded as no-ops (all enables 0), illegal=0.

Optional Feature:
- Macro IDU_PIPE_M_EXT_EN.
- When defined: adds output muldiv (1 bit). OP and OP-32 with funct7=0000001 set muldiv=1, pass funct3 through as-is, and are not illegal.
- When undefined: the port is absent and funct7=0000001 on OP/OP-32 sets illegal=1.

Decomposition:
- Package idu_pkg holds:
  - Opcode localparams, including OP_IMM_32=00110 and OP_32=01110.
  - Instruction-format enum.
  - mm_size encodings.
  - Packed struct decoded_t carrying all bundle fields, parametrised via XLEN-sized imm/pc members.
- One sub-module, idu_decode_comb: pure combinational instr→decoded_t.
- idu_pipe instantiates idu_decode_comb and owns the skid buffer, handshake and flush.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093, pc 0x100) → next cycle out_valid=1, rd=1, rs1=0, imm=5, op2_imm=1, rd_we=1, rs2=0, pc_out=0x100.
- lui x2,0x12345 (0x12345137) → imm=0x12345000, rd=2, rd_we=1, op2_imm=1, alu_funct3=000. With XLEN=64, 0x80000137 → imm=0xFFFFFFFF80000000.
- Back-pressure: stream 4 instrs with out_ready=0 → after 2 accepts in_ready=0. Raise out_ready → bundles emerge in order, none lost or duplicated, stable while stalled.
- Flush with 2 entries held and in_valid=1 → next cycle out_valid=0. The offered instruction is never output.
- 0x00000000 → illegal=1, all enables 0. lbu x3,4(x1) (0x0040C183) → mm_re=1, mm_size=00, mm_unsigned=1, imm=4, rd=3, rs1=1.
- XLEN=64: addiw x5,x5,-1 (0xFFF2829B) → word_op=1, imm=all ones. Same instruction with XLEN=32 → illegal=1.
